maze_controller: RTL and testbench
==================================

// Module: maze_controller
// PURPOSE
//  Owns the maze cell store and game FSM; arbitrates writes between the maze generator and player moves.
//  Drives i_Maze/i_MazeState of VgaProcessor; copies work buffer to display only at frame edges (no tearing).
//  Grid MAZE_W x MAZE_H cells, 2 bits/cell, cell (x,y) at bits [(y*MAZE_W+x)*2 +: 2].
// PARAMETERS
//  MAZE_W      40     cells per row
//  MAZE_H      30     rows
//  START_X     1      player start column
//  START_Y     1      player start row
//  VSYNC_POL   0      active level of i_VSync; frame edge = entry into active level
//  FRAME_LIMIT 3600   frames allowed in PLAY (MAZE_TIMEOUT_EN only)
// PORTS
//  i_Clk        in   1     system/pixel clock; single clock domain
//  i_Rst_n      in   1     asynchronous reset, active-low
//  i_Start      in   1     start/restart request (level; sampled in IDLE, WIN, LOSE)
//  i_VSync      in   1     VgaProcessor vertical sync, same clock domain
//  o_Gen_Start  out  1     one-cycle pulse: generator begin
//  i_Gen_Req    in   1     generator cell-write strobe
//  i_Gen_Addr   in   11    cell index y*MAZE_W+x
//  i_Gen_Data   in   2     cell code
//  i_Gen_Done   in   1     generation finished (pulse)
//  o_Gen_Ack    out  1     one-cycle pulse, cycle after accepted i_Gen_Req
//  i_Move_Req   in   1     move request, held until o_Move_Ack
//  i_Move_Dir   in   2     0 up, 1 down, 2 left, 3 right
//  o_Move_Ack   out  1     one-cycle pulse completing a request
//  o_Move_Ok    out  1     valid with ack: 1 moved, 0 rejected
//  o_Maze       out  2400  display buffer to VgaProcessor
//  o_MazeState  out  2     0 IDLE, 1 PLAY (incl. CLEAR/GEN), 2 WIN, 3 LOSE
// BEHAVIOUR
//  Reset: work and display buffers all 0 (PATH), o_MazeState 0, all pulses/acks 0, player at (START_X,START_Y), FSM IDLE.
//  Cells: 0 PATH, 1 WALL, 2 PLAYER, 3 GOAL.
//  FSM: IDLE -i_Start-> CLEAR (1 cycle: work buffer all WALL) -> GEN (o_Gen_Start pulses on entry).
//  GEN: each i_Gen_Req writes work cell, o_Gen_Ack next cycle; addr >= MAZE_W*MAZE_H acked, no write.
//   i_Gen_Done: write PLAYER at start cell, go PLAY. Req+Done same cycle: write applied, then PLAYER overwrites start.
//  PLAY: accepted move -> target = pos +/- 1 per dir; ack + o_Move_Ok one cycle later; next accept earliest the cycle after ack.
//   Target off-grid (wrap not allowed, e.g. x=0 left) or WALL: reject, nothing changes.
//   PATH: old cell <- PATH, target <- PLAYER, pos updated, Ok=1.
//   GOAL: same move, Ok=1, FSM -> WIN.
//  WIN/LOSE: buffers frozen; i_Start -> CLEAR. i_Start ignored in CLEAR/GEN/PLAY.
//  Outside GEN: i_Gen_Req never acked. Outside PLAY: i_Move_Req never acked (held until PLAY).
//  Frame edge: registered i_VSync edge detect; cycle after detection o_Maze <= work, o_MazeState <= FSM code.
//   Write lands at display on first frame edge after its cycle; edge and write same cycle -> write in next frame.
//  Reset mid-operation: immediate async return to reset values, incl. display buffer.
// CONFIGURATION
//  `MAZE_TIMEOUT_EN defined: frame counter cleared on PLAY entry, +1 per frame edge in PLAY;
//   reaching FRAME_LIMIT -> LOSE. Move-to-GOAL and limit in same cycle: WIN wins.
//  Undefined: no counter, LOSE unreachable, o_MazeState never 3.
// STRUCTURE
//  Package maze_pkg: MAZE_W/MAZE_H defaults, ADDR_W=11, cell codes, o_MazeState codes, direction codes, FSM enum.
//  Sub-module vga_frame_edge: registers i_VSync, emits one-cycle frame-edge pulse per VSYNC_POL.
// TESTING
//  Reset while in PLAY -> all outputs 0, o_Maze==0 on next cycle, FSM IDLE.
//  i_Start; gen writes addr 41=GOAL, 42=PATH, 1200 (bad), Done -> 3 acks, addr 1200 ignored; after frame edge cells 41=2, 42=0, rest 1.
//  PLAY at (1,1), dir 3 onto PATH (2,1) -> Ack+Ok=1, cell 41 PATH, 42 PLAYER; dir 2 onto WALL (0,1)? place at x=0 -> Ok=0.
//  Player at x=0, dir 2 -> Ok=0, no change (no wrap to x=39).
//  Move onto GOAL -> Ok=1, o_MazeState 2 only after next frame edge; further moves not acked; i_Start -> CLEAR.
//  `MAZE_TIMEOUT_EN, FRAME_LIMIT=4: 4 frame edges in PLAY -> o_MazeState 3; undefined -> stays 1.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and codes for the maze controller: grid defaults, cell codes,
// display state codes, move directions and the game FSM encoding.
package maze_pkg;

    localparam int unsigned MAZE_W_DEF = 40;
    localparam int unsigned MAZE_H_DEF = 30;
    localparam int unsigned ADDR_W     = 11;

    localparam logic [1:0] CELL_PATH   = 2'd0;
    localparam logic [1:0] CELL_WALL   = 2'd1;
    localparam logic [1:0] CELL_PLAYER = 2'd2;
    localparam logic [1:0] CELL_GOAL   = 2'd3;

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_PLAY = 2'd1;
    localparam logic [1:0] MS_WIN  = 2'd2;
    localparam logic [1:0] MS_LOSE = 2'd3;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_GEN, ST_PLAY, ST_WIN, ST_LOSE
    } fsm_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        data;
    } gen_wr_t;

    // CLEAR and GEN are reported as PLAY so the display never shows a half-built maze state.
    function automatic logic [1:0] state_code(input fsm_t s);
        case (s)
            ST_IDLE:                  return MS_IDLE;
            ST_CLEAR, ST_GEN, ST_PLAY: return MS_PLAY;
            ST_WIN:                   return MS_WIN;
            default:                  return MS_LOSE;
        endcase
    endfunction

endpackage

// File: rtl/maze_controller_frame_edge.sv
// Registered VSync edge detector: one-cycle pulse when VSync enters its active level.
module vga_frame_edge #(
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic frame_edge
);

    logic vsync_q;

    // Reset history to the active level so a VSync already active at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= VSYNC_POL;
            frame_edge <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_edge <= (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
        end
    end

endmodule

// File: rtl/maze_controller.sv
// Maze cell store, game FSM and tear-free display copy.
// Optional frame timeout enabled by defining MAZE_TIMEOUT_EN.
module maze_controller
    import maze_pkg::*;
#(
    parameter int unsigned MAZE_W      = MAZE_W_DEF,
    parameter int unsigned MAZE_H      = MAZE_H_DEF,
    parameter int unsigned START_X     = 1,
    parameter int unsigned START_Y     = 1,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned FRAME_LIMIT = 3600
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic                       i_Start,
    input  logic                       i_VSync,
    output logic                       o_Gen_Start,
    input  logic                       i_Gen_Req,
    input  logic [ADDR_W-1:0]          i_Gen_Addr,
    input  logic [1:0]                 i_Gen_Data,
    input  logic                       i_Gen_Done,
    output logic                       o_Gen_Ack,
    input  logic                       i_Move_Req,
    input  logic [1:0]                 i_Move_Dir,
    output logic                       o_Move_Ack,
    output logic                       o_Move_Ok,
    output logic [MAZE_W*MAZE_H*2-1:0] o_Maze,
    output logic [1:0]                 o_MazeState
);

    localparam int unsigned NCELL  = MAZE_W * MAZE_H;
    localparam int unsigned BUF_W  = NCELL * 2;
    localparam int unsigned BIDX_W = $clog2(BUF_W);
    localparam int unsigned XW     = $clog2(MAZE_W);
    localparam int unsigned YW     = $clog2(MAZE_H);
    localparam logic [XW-1:0] SX   = XW'(START_X);
    localparam logic [YW-1:0] SY   = YW'(START_Y);

    fsm_t              state, state_n;
    logic [BUF_W-1:0]  work, work_n, disp_n;
    logic [XW-1:0]     pos_x, pos_x_n, tgt_x;
    logic [YW-1:0]     pos_y, pos_y_n, tgt_y;
    logic              gen_start_n, gen_ack_n, move_ack_n, move_ok_n;
    logic [1:0]        mstate_n, tgt_cell;
    logic              off_grid, frame_edge;
    gen_wr_t           gen_wr;

    function automatic logic [BIDX_W-1:0] cell_bit(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return BIDX_W'((32'(y) * MAZE_W + 32'(x)) * 2);
    endfunction

    assign gen_wr = '{addr: i_Gen_Addr, data: i_Gen_Data};

    vga_frame_edge #(.VSYNC_POL(VSYNC_POL)) u_frame_edge (
        .clk        (i_Clk),
        .rst_n      (i_Rst_n),
        .vsync      (i_VSync),
        .frame_edge (frame_edge)
    );

`ifdef MAZE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(FRAME_LIMIT + 1);
    logic [CNT_W-1:0] fcnt, fcnt_n;
`else
    logic unused_limit;
    assign unused_limit = (FRAME_LIMIT == 0);
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= ST_IDLE;
            work        <= '0;
            pos_x       <= SX;
            pos_y       <= SY;
            o_Gen_Start <= 1'b0;
            o_Gen_Ack   <= 1'b0;
            o_Move_Ack  <= 1'b0;
            o_Move_Ok   <= 1'b0;
            o_Maze      <= '0;
            o_MazeState <= MS_IDLE;
`ifdef MAZE_TIMEOUT_EN
            fcnt        <= '0;
`endif
        end else begin
            state       <= state_n;
            work        <= work_n;
            pos_x       <= pos_x_n;
            pos_y       <= pos_y_n;
            o_Gen_Start <= gen_start_n;
            o_Gen_Ack   <= gen_ack_n;
            o_Move_Ack  <= move_ack_n;
            o_Move_Ok   <= move_ok_n;
            o_Maze      <= disp_n;
            o_MazeState <= mstate_n;
`ifdef MAZE_TIMEOUT_EN
            fcnt        <= fcnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        work_n      = work;
        pos_x_n     = pos_x;
        pos_y_n     = pos_y;
        gen_start_n = 1'b0;
        gen_ack_n   = 1'b0;
        move_ack_n  = 1'b0;
        move_ok_n   = 1'b0;
        disp_n      = o_Maze;
        mstate_n    = o_MazeState;
        tgt_x       = pos_x;
        tgt_y       = pos_y;
        off_grid    = 1'b0;
        tgt_cell    = CELL_WALL;
`ifdef MAZE_TIMEOUT_EN
        fcnt_n      = fcnt;
`endif

        // Neighbour cell; edges never wrap to the opposite side.
        case (i_Move_Dir)
            DIR_UP:    if (pos_y == '0) off_grid = 1'b1; else tgt_y = pos_y - YW'(1);
            DIR_DOWN:  if (pos_y == YW'(MAZE_H - 1)) off_grid = 1'b1; else tgt_y = pos_y + YW'(1);
            DIR_LEFT:  if (pos_x == '0) off_grid = 1'b1; else tgt_x = pos_x - XW'(1);
            default:   if (pos_x == XW'(MAZE_W - 1)) off_grid = 1'b1; else tgt_x = pos_x + XW'(1);
        endcase
        if (!off_grid)
            tgt_cell = work[cell_bit(tgt_x, tgt_y) +: 2];

        case (state)
            ST_IDLE: if (i_Start) state_n = ST_CLEAR;
            ST_CLEAR: begin
                work_n      = {NCELL{CELL_WALL}};
                pos_x_n     = SX;
                pos_y_n     = SY;
                gen_start_n = 1'b1;
                state_n     = ST_GEN;
            end
            ST_GEN: begin
                if (i_Gen_Req) begin
                    gen_ack_n = 1'b1;
                    if (32'(gen_wr.addr) < NCELL)
                        work_n[BIDX_W'(32'(gen_wr.addr) * 2) +: 2] = gen_wr.data;
                end
                // Done after the write so the player always overwrites the start cell.
                if (i_Gen_Done) begin
                    work_n[cell_bit(SX, SY) +: 2] = CELL_PLAYER;
                    state_n = ST_PLAY;
`ifdef MAZE_TIMEOUT_EN
                    fcnt_n  = '0;
`endif
                end
            end
            ST_PLAY: begin
                if (i_Move_Req && !o_Move_Ack) begin
                    move_ack_n = 1'b1;
                    if (!off_grid && tgt_cell != CELL_WALL) begin
                        move_ok_n = 1'b1;
                        work_n[cell_bit(pos_x, pos_y) +: 2] = CELL_PATH;
                        work_n[cell_bit(tgt_x, tgt_y) +: 2] = CELL_PLAYER;
                        pos_x_n = tgt_x;
                        pos_y_n = tgt_y;
                        if (tgt_cell == CELL_GOAL)
                            state_n = ST_WIN;
                    end
                end
`ifdef MAZE_TIMEOUT_EN
                // A winning move on the limiting frame keeps the win.
                if (frame_edge) begin
                    fcnt_n = fcnt + CNT_W'(1);
                    if (fcnt_n >= CNT_W'(FRAME_LIMIT) && state_n == ST_PLAY)
                        state_n = ST_LOSE;
                end
`endif
            end
            ST_WIN, ST_LOSE: if (i_Start) state_n = ST_CLEAR;
            default: state_n = ST_IDLE;
        endcase

        if (frame_edge) begin
            disp_n   = work;
            mstate_n = state_code(state);
        end
    end

endmodule

// File: tb/tb_maze_controller.sv
// Self-checking bench for maze_controller: directed table of moves plus randomized
// generation and moves checked against a cell-array reference model.
module tb_maze_controller;

    localparam int W = 40;
    localparam int H = 30;
    localparam int N = W * H;
    localparam int SX = 1;
    localparam int SY = 1;
    localparam int TB_LIMIT = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, vsync;
    logic            gen_start, gen_req, gen_done, gen_ack;
    logic [10:0]     gen_addr;
    logic [1:0]      gen_data, move_dir, maze_state;
    logic            move_req, move_ack, move_ok;
    logic [N*2-1:0]  maze;

    maze_controller #(.FRAME_LIMIT(TB_LIMIT)) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Start     (start),
        .i_VSync     (vsync),
        .o_Gen_Start (gen_start),
        .i_Gen_Req   (gen_req),
        .i_Gen_Addr  (gen_addr),
        .i_Gen_Data  (gen_data),
        .i_Gen_Done  (gen_done),
        .o_Gen_Ack   (gen_ack),
        .i_Move_Req  (move_req),
        .i_Move_Dir  (move_dir),
        .o_Move_Ack  (move_ack),
        .o_Move_Ok   (move_ok),
        .o_Maze      (maze),
        .o_MazeState (maze_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain cell arrays and a game-state code (0 idle, 1 play, 2 win, 3 lose).
    int work_m[N];
    int disp_m[N];
    int px, py, mst, dst, fcnt;

    typedef struct {
        int dir;
        int ok;
        int x;
        int y;
    } vec_t;
    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cell_at(input int i);
        return int'(2'(maze >> (i * 2)));
    endfunction

    task automatic check_maze(input string name);
        int bad = -1;
        checks++;
        for (int i = 0; i < N; i++)
            if (bad < 0 && cell_at(i) != disp_m[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: cell %0d got %0d expected %0d", name, bad, cell_at(bad), disp_m[bad]);
        end
        check({name, "_state"}, int'(maze_state), dst);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            work_m[i] = 0;
            disp_m[i] = 0;
        end
        px = SX; py = SY; mst = 0; dst = 0; fcnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 0; vsync = 1; gen_req = 0; gen_done = 0; gen_addr = '0; gen_data = '0;
        move_req = 0; move_dir = '0;
        repeat (2) tick();
        model_reset();
        rst_n = 1'b1;
        tick();
    endtask

    // One frame: VSync active-low pulse, then let the copy settle.
    task automatic frame();
        vsync = 1'b0;
        repeat (3) tick();
        vsync = 1'b1;
        repeat (3) tick();
        disp_m = work_m;
        dst = mst;
`ifdef MAZE_TIMEOUT_EN
        if (mst == 1) begin
            fcnt++;
            if (fcnt >= TB_LIMIT) mst = 3;
        end
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("gen_start_clear", int'(gen_start), 0);
        tick();
        check("gen_start_pulse", int'(gen_start), 1);
        tick();
        check("gen_start_end", int'(gen_start), 0);
        for (int i = 0; i < N; i++) work_m[i] = 1;
        px = SX; py = SY; mst = 1;
    endtask

    task automatic gen_write(input int addr, input int data, input bit done);
        gen_req = 1'b1; gen_addr = 11'(addr); gen_data = 2'(data); gen_done = done;
        tick();
        gen_req = 1'b0; gen_done = 1'b0;
        check("gen_ack", int'(gen_ack), 1);
        if (addr < N) work_m[addr] = data;
        if (done) begin
            work_m[SY * W + SX] = 2;
            fcnt = 0;
        end
        tick();
        check("gen_ack_pulse", int'(gen_ack), 0);
    endtask

    task automatic gen_finish();
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        work_m[SY * W + SX] = 2;
        fcnt = 0;
        tick();
    endtask

    task automatic do_move(input int dir, output int got_ok);
        int tx = px, ty = py, c, exp_ok = 0;
        bit seen = 0;
        got_ok = -1;
        move_req = 1'b1; move_dir = 2'(dir);
        if (mst == 1) begin
            case (dir)
                0: ty--;
                1: ty++;
                2: tx--;
                default: tx++;
            endcase
            if (tx >= 0 && tx < W && ty >= 0 && ty < H) begin
                c = work_m[ty * W + tx];
                if (c != 1) begin
                    exp_ok = 1;
                    work_m[py * W + px] = 0;
                    work_m[ty * W + tx] = 2;
                    px = tx; py = ty;
                    if (c == 3) mst = 2;
                end
            end
            tick();
            check("move_ack", int'(move_ack), 1);
            check("move_ok", int'(move_ok), exp_ok);
            got_ok = int'(move_ok);
            tick();
            move_req = 1'b0;
            check("move_ack_pulse", int'(move_ack), 0);
        end else begin
            repeat (4) begin
                tick();
                if (move_ack) seen = 1;
            end
            move_req = 1'b0;
            check("move_no_ack", int'(seen), 0);
        end
    endtask

    initial begin
        int ok, seen;
        vecs[0]  = '{0, 0, 1, 1};
        vecs[1]  = '{1, 1, 1, 2};
        vecs[2]  = '{1, 0, 1, 2};
        vecs[3]  = '{0, 1, 1, 1};
        vecs[4]  = '{2, 1, 0, 1};
        vecs[5]  = '{2, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 1};
        vecs[7]  = '{3, 1, 1, 1};
        vecs[8]  = '{3, 1, 2, 1};
        vecs[9]  = '{3, 1, 3, 1};
        vecs[10] = '{3, 0, 3, 1};
        vecs[11] = '{0, 1, 3, 0};

        do_reset();
        check("rst_maze_zero", int'(|maze), 0);
        check("rst_state", int'(maze_state), 0);
        check("rst_gen_start", int'(gen_start), 0);
        check("rst_acks", int'({gen_ack, move_ack, move_ok}), 0);

        // Requests outside their phases are never acknowledged.
        gen_req = 1'b1; gen_addr = 11'd5; gen_data = 2'd3;
        seen = 0;
        repeat (3) begin
            tick();
            if (gen_ack) seen = 1;
        end
        gen_req = 1'b0;
        check("idle_gen_no_ack", seen, 0);
        do_move(3, ok);

        // Directed generation with a bad address, then first moves.
        do_start();
        gen_write(41, 3, 0);
        gen_write(42, 0, 0);
        gen_write(1200, 0, 0);
        gen_write(79, 0, 0);
        gen_finish();
        frame();
        check_maze("gen_a");
        check("cell41", cell_at(41), 2);
        check("cell42", cell_at(42), 0);
        check("cell0", cell_at(0), 1);
        do_move(3, ok);
        do_move(2, ok);
        do_move(2, ok);
        frame();
        check_maze("moves_a");

        // Asynchronous reset in the middle of a game.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_maze_zero", int'(|maze), 0);
        check("async_state", int'(maze_state), 0);
        check("async_acks", int'({gen_start, gen_ack, move_ack, move_ok}), 0);
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        check("post_rst_maze_zero", int'(|maze), 0);
        do_move(1, ok);
        frame();
        check_maze("post_rst");

        // Table-driven game including no-wrap and goal.
        do_start();
        gen_write(40, 0, 0);
        gen_write(42, 0, 0);
        gen_write(43, 0, 0);
        gen_write(81, 0, 0);
        gen_write(79, 0, 0);
        gen_write(3, 3, 0);
        gen_finish();
        frame();
        check_maze("gen_b");
        for (int v = 0; v < 12; v++) begin
            do_move(vecs[v].dir, ok);
            check($sformatf("vec%0d_ok", v), ok, vecs[v].ok);
            check($sformatf("vec%0d_disp_state", v), int'(maze_state), 1);
            frame();
            check($sformatf("vec%0d_pos", v), cell_at(vecs[v].y * W + vecs[v].x), 2);
        end
        check_maze("table_end");
        check("win_state", int'(maze_state), 2);
        do_move(1, ok);

        // Restart from WIN; random maze with Req+Done on the start cell.
        do_start();
        for (int i = 0; i < 80; i++) begin
            int r = int'($urandom_range(0, 9));
            gen_write(int'($urandom_range(0, 1260)), (r < 6) ? 0 : (r < 9) ? 1 : 3, 0);
        end
        gen_write(SY * W + SX, int'($urandom_range(0, 3)), 1);
        frame();
        check_maze("gen_rand");
        start = 1'b1;
        seen = 0;
        repeat (3) begin
            tick();
            if (gen_start) seen = 1;
        end
        start = 1'b0;
        check("start_ignored_play", seen, 0);
        for (int m = 0; m < 150; m++) begin
            do_move(int'($urandom_range(0, 3)), ok);
            if (m % 16 == 15) begin
                frame();
                check_maze("rand_frame");
            end
        end
        frame();
        check_maze("rand_end");

        // Frame budget: LOSE only with the timeout build.
        do_reset();
        do_start();
        gen_finish();
        for (int f = 0; f <= TB_LIMIT; f++) frame();
        check_maze("timeout");
`ifdef MAZE_TIMEOUT_EN
        check("timeout_state", int'(maze_state), 3);
`else
        check("timeout_state", int'(maze_state), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
